rx_seq_ctrl: RTL and testbench

Receiver frame sequencer for the OFDM receive chain. It derives the per-sample strobe from the fast clock, which replaces the ClkDiv-based slow clock. It tracks the frame through short-preamble search, long-preamble wait and data symbols, and drives the FFT window, symbol count and end-of-frame/timeout pulses consumed by the synchronizer and FFT/demapper stages.

---
 rtl/rx_seq_ctrl.sv | 177 +++++++++++++++++
 tb/tb_rx_seq_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/rx_seq_ctrl.sv
// OFDM receive frame sequencer: sample-strobe divider plus SEARCH/WAIT_LTS/DATA_CP/DATA_FFT/DONE control.
// Optional LTS timeout is compiled in with `define RX_SEQ_TIMEOUT_EN.
module rx_seq_ctrl #(
  parameter int DIV_RATIO   = 30,
  parameter int SYM_LEN     = 80,
  parameter int CP_LEN      = 16,
  parameter int LTS_TIMEOUT = 320,
  parameter int NSYM_W      = 8
) (
  input  logic              CLK,
  input  logic              s_RST_n,
  input  logic              enable,
  input  logic              abort,
  input  logic              sts_detect,
  input  logic              lts_detect,
  input  logic [NSYM_W-1:0] n_sym,
  output logic              sample_strobe,
  output logic              sync_clr,
  output logic              fft_win,
  output logic              fft_start,
  output logic [NSYM_W-1:0] sym_cnt,
  output logic              frame_done,
  output logic              timeout,
  output logic [2:0]        state
);
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEARCH   = 3'd1,
    WAIT_LTS = 3'd2,
    DATA_CP  = 3'd3,
    DATA_FFT = 3'd4,
    DONE     = 3'd5
  } state_t;

  localparam int DIV_W  = (DIV_RATIO > 1) ? $clog2(DIV_RATIO) : 1;
  localparam int SAMP_W = $clog2(SYM_LEN);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(DIV_RATIO - 1);
  localparam logic [SAMP_W-1:0] CP_LAST  = SAMP_W'(CP_LEN - 1);
  localparam logic [SAMP_W-1:0] FFT_LAST = SAMP_W'(SYM_LEN - CP_LEN - 1);
  localparam logic [NSYM_W-1:0] SYM_MAX  = '1;

  state_t              cur, nx_state;
  logic [DIV_W-1:0]    div_cnt;
  logic                div_wrap;
  logic [SAMP_W-1:0]   samp_cnt, nx_samp;
  logic [NSYM_W-1:0]   nx_sym;
  logic [NSYM_W-1:0]   n_sym_q, nx_nsym;
  logic                nx_sync_clr;
  logic                to_hit;

  assign state    = cur;
  assign div_wrap = (div_cnt == DIV_LAST);

  // Disable acts exactly like reset on every register.
  always_ff @(posedge CLK) begin
    if (!s_RST_n || !enable) begin
      div_cnt       <= '0;
      sample_strobe <= 1'b0;
    end else begin
      div_cnt       <= div_wrap ? '0 : div_cnt + 1'b1;
      sample_strobe <= div_wrap;
    end
  end

`ifdef RX_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(LTS_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(LTS_TIMEOUT - 1);
  logic [TO_W-1:0] to_cnt;

  assign to_hit = (cur == WAIT_LTS) && sample_strobe && (to_cnt == TO_LAST);

  always_ff @(posedge CLK) begin
    if (!s_RST_n || !enable) begin
      to_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= to_hit && !abort && !lts_detect;
      if (cur == SEARCH || (cur == WAIT_LTS && sts_detect))
        to_cnt <= '0;
      else if (cur == WAIT_LTS && sample_strobe)
        to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  assign to_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    nx_state    = cur;
    nx_samp     = samp_cnt;
    nx_sym      = sym_cnt;
    nx_nsym     = n_sym_q;
    nx_sync_clr = 1'b0;
    if (abort && cur != IDLE) begin
      nx_state    = SEARCH;
      nx_sync_clr = 1'b1;
    end else begin
      case (cur)
        IDLE: begin
          nx_state    = SEARCH;
          nx_sync_clr = 1'b1;
        end
        SEARCH: begin
          if (sts_detect) begin
            nx_state = WAIT_LTS;
            nx_samp  = '0;
          end
        end
        WAIT_LTS: begin
          if (lts_detect) begin
            nx_samp  = '0;
            nx_sym   = '0;
            nx_nsym  = n_sym;
            nx_state = (n_sym == '0) ? DONE : DATA_CP;
          end else if (to_hit) begin
            nx_state    = SEARCH;
            nx_sync_clr = 1'b1;
          end
        end
        DATA_CP: begin
          if (sample_strobe) begin
            if (samp_cnt == CP_LAST) begin
              nx_samp  = '0;
              nx_state = DATA_FFT;
            end else begin
              nx_samp = samp_cnt + 1'b1;
            end
          end
        end
        DATA_FFT: begin
          if (sample_strobe) begin
            if (samp_cnt == FFT_LAST) begin
              nx_samp = '0;
              if (sym_cnt == n_sym_q - 1'b1) begin
                nx_state = DONE;
              end else begin
                nx_state = DATA_CP;
                if (sym_cnt != SYM_MAX) nx_sym = sym_cnt + 1'b1;
              end
            end else begin
              nx_samp = samp_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          nx_state    = SEARCH;
          nx_sync_clr = 1'b1;
        end
        default: nx_state = IDLE;
      endcase
    end
  end

  // fft_start is timed to land in the same cycle as the first FFT-sample strobe.
  always_ff @(posedge CLK) begin
    if (!s_RST_n || !enable) begin
      cur        <= IDLE;
      samp_cnt   <= '0;
      sym_cnt    <= '0;
      n_sym_q    <= '0;
      sync_clr   <= 1'b0;
      fft_win    <= 1'b0;
      fft_start  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      cur        <= nx_state;
      samp_cnt   <= nx_samp;
      sym_cnt    <= nx_sym;
      n_sym_q    <= nx_nsym;
      sync_clr   <= nx_sync_clr;
      fft_win    <= (nx_state == DATA_FFT);
      fft_start  <= div_wrap && (nx_state == DATA_FFT) && (nx_samp == '0);
      frame_done <= (nx_state == DONE);
    end
  end
endmodule

// File: tb/tb_rx_seq_ctrl.sv
// Directed bench for rx_seq_ctrl: reset, strobe timing, nominal frame, n_sym=0, abort, timeout, mid-frame reset, disable.
module tb_rx_seq_ctrl;
  logic       CLK = 1'b0;
  logic       s_RST_n, enable, abort, sts_detect, lts_detect;
  logic [7:0] n_sym;
  logic       sample_strobe, sync_clr, fft_win, fft_start, frame_done, timeout;
  logic [7:0] sym_cnt;
  logic [2:0] state;

  int tests = 0;
  int fails = 0;

  rx_seq_ctrl dut (
    .CLK(CLK), .s_RST_n(s_RST_n), .enable(enable), .abort(abort),
    .sts_detect(sts_detect), .lts_detect(lts_detect), .n_sym(n_sym),
    .sample_strobe(sample_strobe), .sync_clr(sync_clr), .fft_win(fft_win),
    .fft_start(fft_start), .sym_cnt(sym_cnt), .frame_done(frame_done),
    .timeout(timeout), .state(state)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int all_outs();
    return int'({sample_strobe, sync_clr, fft_win, fft_start, frame_done, timeout, state, sym_cnt});
  endfunction

  task automatic pulse_sts();
    sts_detect = 1'b1;
    tick();
    sts_detect = 1'b0;
  endtask

  task automatic pulse_lts(input logic [7:0] ns);
    n_sym      = ns;
    lts_detect = 1'b1;
    tick();
    lts_detect = 1'b0;
  endtask

  initial begin
    int n, m, strobes, starts, bad_starts, sync_cnt, dones, tos;
    int win_cnt[4];
    int sym_at_start[4];
    bit seen;

    s_RST_n = 1'b0; enable = 1'b0; abort = 1'b0;
    sts_detect = 1'b0; lts_detect = 1'b0; n_sym = '0;

    // Reset held for 5 cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      check("reset_outs", all_outs(), 0);
    end

    s_RST_n = 1'b1;
    enable  = 1'b1;
    tick();
    n = 1;
    check("enable_state_search", int'(state), 1);
    sync_cnt = int'(sync_clr);
    while (!sample_strobe && n < 100) begin
      tick();
      n++;
      sync_cnt += int'(sync_clr);
    end
    check("first_strobe_latency", n, 30);
    check("sync_clr_once", sync_cnt, 1);
    m = 0;
    do begin
      tick();
      m++;
    end while (!sample_strobe && m < 100);
    check("strobe_period", m, 30);

    // Nominal frame, n_sym = 3
    pulse_sts();
    check("sts_to_wait_lts", int'(state), 2);
    tick(); tick(); tick();
    pulse_lts(8'd3);
    check("lts_to_data_cp", int'(state), 3);
    check("lts_sym_cnt", int'(sym_cnt), 0);
    strobes = 0; starts = 0; bad_starts = 0; seen = 1'b0;
    for (int i = 0; i < 4; i++) begin win_cnt[i] = 0; sym_at_start[i] = -1; end
    for (int c = 0; c < 8000 && !seen; c++) begin
      if (sample_strobe) begin
        strobes++;
        if (fft_win && sym_cnt < 4) win_cnt[sym_cnt]++;
      end
      if (fft_start) begin
        if (!sample_strobe) bad_starts++;
        if (starts < 4) sym_at_start[starts] = int'(sym_cnt);
        starts++;
      end
      if (frame_done) seen = 1'b1;
      else tick();
    end
    check("nominal_frame_done_seen", int'(seen), 1);
    check("nominal_strobes_to_done", strobes, 240);
    check("nominal_fft_starts", starts, 3);
    check("fft_start_with_strobe", bad_starts, 0);
    for (int s = 0; s < 3; s++) begin
      check("fft_win_strobes_per_sym", win_cnt[s], 64);
      check("sym_cnt_at_fft_start", sym_at_start[s], s);
    end
    check("done_state", int'(state), 5);
    check("done_fft_win_low", int'(fft_win), 0);
    tick();
    check("after_done_search", int'(state), 1);
    check("after_done_sync_clr", int'(sync_clr), 1);
    check("frame_done_one_cycle", int'(frame_done), 0);
    check("sym_cnt_holds_in_search", int'(sym_cnt), 2);

    // n_sym = 0 goes straight to DONE
    tick();
    pulse_sts();
    tick();
    pulse_lts(8'd0);
    check("nsym0_state_done", int'(state), 5);
    check("nsym0_frame_done", int'(frame_done), 1);
    check("nsym0_no_fft_start", int'(fft_start), 0);
    tick();
    check("nsym0_back_search", int'(state), 1);

    // Abort during DATA_FFT of symbol 1, with lts_detect in the same cycle
    tick();
    pulse_sts();
    tick();
    pulse_lts(8'd3);
    seen = 1'b0;
    for (int c = 0; c < 5000 && !seen; c++) begin
      if (fft_win && sym_cnt == 8'd1) seen = 1'b1;
      else tick();
    end
    check("abort_reached_sym1_fft", int'(seen), 1);
    tick(); tick(); tick();
    abort = 1'b1; lts_detect = 1'b1;
    tick();
    abort = 1'b0; lts_detect = 1'b0;
    check("abort_state_search", int'(state), 1);
    check("abort_fft_win_low", int'(fft_win), 0);
    check("abort_sync_clr", int'(sync_clr), 1);
    check("abort_sym_cnt_holds", int'(sym_cnt), 1);
    dones = 0;
    for (int c = 0; c < 300; c++) begin
      dones += int'(frame_done);
      tick();
    end
    check("abort_no_frame_done", dones, 0);

    // LTS timeout
    pulse_sts();
    check("timeout_wait_lts", int'(state), 2);
    strobes = 0; tos = 0;
`ifdef RX_SEQ_TIMEOUT_EN
    seen = 1'b0;
    for (int c = 0; c < 11000 && !seen; c++) begin
      tick();
      if (sample_strobe) strobes++;
      if (timeout) seen = 1'b1;
    end
    check("timeout_seen", int'(seen), 1);
    check("timeout_strobe_count", strobes, 320);
    check("timeout_state_search", int'(state), 1);
    check("timeout_sync_clr", int'(sync_clr), 1);
    tick();
    check("timeout_one_cycle", int'(timeout), 0);
`else
    while (strobes < 1001) begin
      tick();
      if (sample_strobe) strobes++;
      tos += int'(timeout);
    end
    check("no_timeout_state_wait", int'(state), 2);
    check("no_timeout_pulses", tos, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("no_timeout_abort_search", int'(state), 1);
`endif

    // Mid-frame reset during DATA_CP
    tick();
    pulse_sts();
    tick();
    pulse_lts(8'd2);
    tick(); tick();
    check("midrst_in_data_cp", int'(state), 3);
    s_RST_n = 1'b0;
    tick();
    s_RST_n = 1'b1;
    check("midrst_outs_zero", all_outs(), 0);
    tick();
    check("midrst_search", int'(state), 1);
    check("midrst_sync_clr", int'(sync_clr), 1);

    // enable low beats abort, inside DATA_FFT
    pulse_sts();
    tick();
    pulse_lts(8'd1);
    seen = 1'b0;
    for (int c = 0; c < 1000 && !seen; c++) begin
      if (fft_win) seen = 1'b1;
      else tick();
    end
    check("disable_reached_fft", int'(seen), 1);
    enable = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    check("disable_outs_zero", all_outs(), 0);
    tick();
    check("disable_stays_idle", int'(state), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
